// File: rtl/itcm_arb_pkg.sv
// Shared types and sizing for the ITCM arbiter: bus widths, owner-tag
// encoding and the default starvation limit.
package itcm_arb_pkg;

  localparam int unsigned ADDR_WIDTH       = 16;
  localparam int unsigned INSTR_WIDTH      = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Who owns the read response arriving on the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/itcm_arb_if.sv
// Bundle of requester-side and ITCM-side signals of the ITCM arbiter.
// slave: the arbiter's view; master: the environment's view.
interface itcm_arb_if;
  import itcm_arb_pkg::*;

  logic                   i_req;
  logic                   i_gnt;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic [INSTR_WIDTH-1:0] i_rdata;
  logic                   i_rvalid;

  logic                   d_req;
  logic                   d_we;
  logic                   d_gnt;
  logic [3:0]             d_be;
  logic [ADDR_WIDTH-1:0]  d_addr;
  logic [31:0]            d_wdata;
  logic [31:0]            d_rdata;
  logic                   d_rvalid;

  logic                   al_active;
  logic                   al_req;
  logic                   al_gnt;
  logic [ADDR_WIDTH-1:0]  al_addr;
  logic [31:0]            al_wdata;

  logic                   itcm_en;
  logic                   itcm_we;
  logic [3:0]             itcm_be;
  logic [ADDR_WIDTH-1:0]  itcm_addr;
  logic [31:0]            itcm_wdata;
  logic [31:0]            itcm_rdata;
  logic                   itcm_auto_load;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  al_active, al_req, al_addr, al_wdata,
    input  itcm_rdata,
    output i_gnt, i_rdata, i_rvalid,
    output d_gnt, d_rdata, d_rvalid,
    output al_gnt,
    output itcm_en, itcm_we, itcm_be, itcm_addr, itcm_wdata, itcm_auto_load
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output al_active, al_req, al_addr, al_wdata,
    output itcm_rdata,
    input  i_gnt, i_rdata, i_rvalid,
    input  d_gnt, d_rdata, d_rvalid,
    input  al_gnt,
    input  itcm_en, itcm_we, itcm_be, itcm_addr, itcm_wdata, itcm_auto_load
  );

endinterface

// File: rtl/itcm_arb_prio.sv
// Grant selection for the ITCM arbiter. Auto-load owns the port while
// active; otherwise data beats instruction. With KRV_ITCM_ARB_STARVE_EN
// defined, a saturating counter of denied fetch cycles promotes the
// instruction port once it reaches STARVE_LIMIT.
module itcm_arb_prio
  import itcm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
`ifdef KRV_ITCM_ARB_STARVE_EN
  input  logic cpu_clk,
`endif
  input  logic cpu_rstn,
  input  logic al_active_i,
  input  logic al_req_i,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_o,
  output logic d_gnt_o,
  output logic al_gnt_o
);

  if ((STARVE_LIMIT < 32'd1) || (STARVE_LIMIT > 32'd15)) begin : g_limit_bad
    $error("itcm_arb_prio: STARVE_LIMIT must be within 1..15");
  end

  logic promote_s;

`ifdef KRV_ITCM_ARB_STARVE_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign promote_s = (starve_q == 4'(STARVE_LIMIT));

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_d = 4'd0;
    if (i_req_i && !i_gnt_o) begin
      if (promote_s) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      starve_d = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign promote_s = 1'b0;
`endif

  // One-hot grant; nothing is granted while reset is asserted.
  always_comb begin
    i_gnt_o  = 1'b0;
    d_gnt_o  = 1'b0;
    al_gnt_o = 1'b0;
    if (!cpu_rstn) begin
      al_gnt_o = 1'b0;
    end else if (al_active_i) begin
      al_gnt_o = al_req_i;
    end else if (i_req_i && (promote_s || !d_req_i)) begin
      i_gnt_o = 1'b1;
    end else begin
      d_gnt_o = d_req_i;
    end
  end

endmodule

// File: rtl/itcm_arb.sv
// ITCM arbiter top: grants one of auto-load / data / instruction per cycle,
// drives the ITCM with the winner's request and routes the one-cycle-late
// read data back to the owner. Optional feature macro:
// KRV_ITCM_ARB_STARVE_EN (fetch starvation promotion).
module itcm_arb
  import itcm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic       cpu_clk,
  input logic       cpu_rstn,
  itcm_arb_if.slave bus
);

  owner_e owner_q;
  owner_e owner_d;
  logic   auto_load_q;

  itcm_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
`ifdef KRV_ITCM_ARB_STARVE_EN
    .cpu_clk     (cpu_clk),
`endif
    .cpu_rstn    (cpu_rstn),
    .al_active_i (bus.al_active),
    .al_req_i    (bus.al_req),
    .i_req_i     (bus.i_req),
    .d_req_i     (bus.d_req),
    .i_gnt_o     (bus.i_gnt),
    .d_gnt_o     (bus.d_gnt),
    .al_gnt_o    (bus.al_gnt)
  );

  assign bus.itcm_en = bus.i_gnt | bus.d_gnt | bus.al_gnt;

  // Drive the ITCM from the granted requester; idle values otherwise.
  always_comb begin
    bus.itcm_we    = 1'b0;
    bus.itcm_be    = 4'h0;
    bus.itcm_addr  = ADDR_WIDTH'(0);
    bus.itcm_wdata = 32'd0;
    if (bus.al_gnt) begin
      bus.itcm_we    = 1'b1;
      bus.itcm_be    = 4'hF;
      bus.itcm_addr  = bus.al_addr;
      bus.itcm_wdata = bus.al_wdata;
    end else if (bus.d_gnt) begin
      bus.itcm_we    = bus.d_we;
      bus.itcm_be    = bus.d_be;
      bus.itcm_addr  = bus.d_addr;
      bus.itcm_wdata = bus.d_wdata;
    end else if (bus.i_gnt) begin
      bus.itcm_we    = 1'b0;
      bus.itcm_be    = 4'hF;
      bus.itcm_addr  = bus.i_addr;
      bus.itcm_wdata = 32'd0;
    end else begin
      bus.itcm_we    = 1'b0;
    end
  end

  // Tag granted reads with their owner; writes and idle cycles tag NONE.
  always_comb begin
    owner_d = OWN_NONE;
    if (bus.al_gnt) begin
      owner_d = OWN_NONE;
    end else if (bus.d_gnt) begin
      owner_d = bus.d_we ? OWN_NONE : OWN_DATA;
    end else if (bus.i_gnt) begin
      owner_d = OWN_INSTR;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // Owner tag and delayed auto-load flag.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      owner_q     <= OWN_NONE;
      auto_load_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      auto_load_q <= bus.al_active;
    end
  end

  assign bus.i_rvalid       = (owner_q == OWN_INSTR);
  assign bus.d_rvalid       = (owner_q == OWN_DATA);
  assign bus.i_rdata        = bus.i_rvalid ? bus.itcm_rdata[INSTR_WIDTH-1:0] : INSTR_WIDTH'(0);
  assign bus.d_rdata        = bus.d_rvalid ? bus.itcm_rdata : 32'd0;
  assign bus.itcm_auto_load = auto_load_q;

endmodule

// File: tb/tb_itcm_arb.sv
// Scoreboard bench for itcm_arb: the stimulus process predicts grants and
// read responses with a cycle-level reference model and queues them; a
// negedge monitor pops and compares against the DUT.
module tb_itcm_arb;
  import itcm_arb_pkg::*;

  localparam int unsigned LIMIT = 4;
`ifdef KRV_ITCM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic cpu_clk  = 1'b0;
  logic cpu_rstn = 1'b0;

  itcm_arb_if bus ();

  itcm_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit                    rstn, al, alr, ir, dr, dwe;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] ia, da, aa;
    logic [31:0]           dw, aw;
  } stim_t;

  typedef struct {
    int                    cyc;
    bit                    i_g, d_g, al_g, en, we, auto_ld;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } gexp_t;

  typedef struct {
    int          cyc;
    bit          is_d;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  // reference model state
  int m_cnt      = 0;
  bit prev_al    = 1'b0;
  bit prev_rstn  = 1'b0;

  function automatic logic [31:0] mem_f(input logic [ADDR_WIDTH-1:0] a);
    return {a, ~a} ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] rnd_addr();
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'($urandom());
    a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rstn = 1'b1;
    s.be   = 4'hF;
    s.ia   = rnd_addr();
    s.da   = rnd_addr();
    s.aa   = rnd_addr();
    s.dw   = $urandom();
    s.aw   = $urandom();
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ITCM model: read data valid one cycle after a read strobe, noise otherwise.
  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    bus.itcm_rdata <= (bus.itcm_en && !bus.itcm_we) ? mem_f(bus.itcm_addr) : 32'($urandom());
  end

  // Apply one cycle of stimulus and queue what the DUT should do.
  task automatic drive(input stim_t s);
    gexp_t g;
    rexp_t r;
    @(posedge cpu_clk);
    #1;
    cpu_rstn      = s.rstn;
    bus.al_active = s.al;
    bus.al_req    = s.alr;
    bus.al_addr   = s.aa;
    bus.al_wdata  = s.aw;
    bus.i_req     = s.ir;
    bus.i_addr    = s.ia;
    bus.d_req     = s.dr;
    bus.d_we      = s.dwe;
    bus.d_be      = s.be;
    bus.d_addr    = s.da;
    bus.d_wdata   = s.dw;

    g = '{default: 0};
    g.cyc = cyc;
    if (s.rstn) begin
      if (s.al)                                                 g.al_g = s.alr;
      else if (s.ir && (!s.dr || (STARVE && m_cnt == int'(LIMIT)))) g.i_g = 1'b1;
      else                                                      g.d_g = s.dr;
    end
    g.en = g.i_g | g.d_g | g.al_g;
    if (g.al_g) begin
      g.we = 1'b1; g.be = 4'hF; g.addr = s.aa; g.wdata = s.aw;
    end else if (g.d_g) begin
      g.we = s.dwe; g.be = s.be; g.addr = s.da; g.wdata = s.dw;
    end else if (g.i_g) begin
      g.addr = s.ia;
    end
    g.auto_ld = s.rstn && prev_rstn && prev_al;

    // starvation count: denied fetch cycles in a row, capped at LIMIT
    if (!s.rstn)                m_cnt = 0;
    else if (s.ir && !g.i_g)    m_cnt = (m_cnt + 1 > int'(LIMIT)) ? int'(LIMIT) : m_cnt + 1;
    else                        m_cnt = 0;

    // reset drops any response due in this cycle
    if (!s.rstn) begin
      while (rq.size() > 0 && rq[$].cyc == cyc) void'(rq.pop_back());
    end
    if (g.i_g || (g.d_g && !s.dwe)) begin
      r.cyc  = cyc + 1;
      r.is_d = g.d_g;
      r.data = mem_f(g.addr);
      rq.push_back(r);
    end
    prev_al   = s.al;
    prev_rstn = s.rstn;
    gq.push_back(g);
  endtask

  gexp_t       mg;
  rexp_t       mr;
  bit          exp_iv, exp_dv;
  logic [31:0] exp_data;

  // Monitor: compare grants, ITCM strobes and read responses each cycle.
  always @(negedge cpu_clk) begin
    if (gq.size() > 0) begin
      mg = gq.pop_front();
      check("cycle_align", 64'(cyc), 64'(mg.cyc));
      check("i_gnt", bus.i_gnt, mg.i_g);
      check("d_gnt", bus.d_gnt, mg.d_g);
      check("al_gnt", bus.al_gnt, mg.al_g);
      check("itcm_en", bus.itcm_en, mg.en);
      if (mg.en) begin
        check("itcm_we", bus.itcm_we, mg.we);
        check("itcm_addr", bus.itcm_addr, mg.addr);
        if (mg.we) begin
          check("itcm_be", bus.itcm_be, mg.be);
          check("itcm_wdata", bus.itcm_wdata, mg.wdata);
        end
      end
      check("itcm_auto_load", bus.itcm_auto_load, mg.auto_ld);
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      exp_data = 32'd0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        mr = rq.pop_front();
        exp_iv = !mr.is_d;
        exp_dv = mr.is_d;
        exp_data = mr.data;
      end
      check("i_rvalid", bus.i_rvalid, exp_iv);
      check("i_rdata", bus.i_rdata, exp_iv ? exp_data : 32'd0);
      check("d_rvalid", bus.d_rvalid, exp_dv);
      check("d_rdata", bus.d_rdata, exp_dv ? exp_data : 32'd0);
    end
  end

  stim_t s;
  bit    al_run;
  bit    hold_i[10];

  initial begin
    // reset with every request raised: no grants may appear
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.rstn = 1'b0; s.al = 1'b1; s.alr = 1'b1; s.ir = 1'b1; s.dr = 1'b1;
      drive(s);
    end
    drive(idle());

    // lone fetch at 0x100
    s = idle(); s.ir = 1'b1; s.ia = 16'h0100; drive(s);
    drive(idle());

    // fetch and data read collide: data wins
    s = idle(); s.ir = 1'b1; s.dr = 1'b1; s.da = 16'h0200; drive(s);
    drive(idle());

    // both held: starvation promotion pattern
    for (int k = 0; k < 10; k++) begin
      s = idle(); s.ir = 1'b1; s.dr = 1'b1; drive(s);
      @(negedge cpu_clk);
      hold_i[k] = bus.i_gnt;
    end
    for (int k = 0; k < 10; k++) begin
      check("starve_pattern", hold_i[k], STARVE && ((k % (int'(LIMIT) + 1)) == int'(LIMIT)));
    end
    drive(idle());

    // data read, then auto-load takes over with everybody requesting
    s = idle(); s.dr = 1'b1; drive(s);
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.al = 1'b1; s.alr = 1'b1; s.ir = 1'b1; s.dr = 1'b1; drive(s);
    end
    s = idle(); s.dr = 1'b1; drive(s);
    drive(idle());

    // reset right after a granted data read, then a normal fetch
    s = idle(); s.dr = 1'b1; drive(s);
    s = idle(); s.rstn = 1'b0; s.dr = 1'b1; drive(s);
    s = idle(); s.ir = 1'b1; drive(s);
    drive(idle());

    // partial data write then fetch back-to-back
    s = idle(); s.dr = 1'b1; s.dwe = 1'b1; s.be = 4'b0011; drive(s);
    s = idle(); s.ir = 1'b1; drive(s);
    drive(idle());

    // randomized traffic
    al_run = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) al_run = !al_run;
      s = idle();
      s.rstn = ($urandom_range(0, 299) != 0);
      s.al   = al_run;
      s.alr  = ($urandom_range(0, 3) != 0);
      s.ir   = ($urandom_range(0, 3) != 0);
      s.dr   = ($urandom_range(0, 1) != 0);
      s.dwe  = ($urandom_range(0, 2) == 0);
      s.be   = 4'($urandom());
      drive(s);
    end
    drive(idle());
    drive(idle());
    @(negedge cpu_clk);
    #1;
    check("queues_drained", 64'(gq.size() + rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
